prog_ctr_ras: RTL and testbench

//  Program counter with a return-address stack (RAS), next generation of the fetch-stage PC.

---
 rtl/pc_pkg.sv | 32 +++
 rtl/ras_stack.sv | 64 ++++++
 rtl/prog_ctr_ras.sv | 133 +++++++++++++
 tb/tb_prog_ctr_ras.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter with return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_JMP  = 3'd1,
    PC_BR   = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OVF  = 2'd1,
    UNF  = 2'd2
  } pc_fault_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_t;

  // Sign-extend the low 'ow' bits of 'off' to 32 bits.
  function automatic logic [31:0] sext_off(input logic [31:0] off, input int unsigned ow);
    logic signed [31:0] tmp;
    tmp = $signed(off << (32'd32 - ow));
    return tmp >>> (32'd32 - ow);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: register array with a fill pointer; the top entry is always presented on rdata.
module ras_stack
  import pc_pkg::*;
#(
  parameter  int A  = 10,
  parameter  int D  = 8,
  localparam int DW = $clog2(D + 1),
  localparam int IW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic [A-1:0]  wdata,
  output logic [A-1:0]  rdata,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [A-1:0]  mem_r [D];
  logic [DW-1:0] ptr_r;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] rd_idx_s;
  logic          do_push_s;
  logic          do_pop_s;

  // Index decode and push/pop qualification against full/empty.
  always_comb begin
    full      = (ptr_r == DW'(D));
    empty     = (ptr_r == DW'(0));
    do_push_s = push && !full && !Reset;
    do_pop_s  = pop && !empty;
    wr_idx_s  = IW'(ptr_r);
    if (empty) begin
      rd_idx_s = IW'(0);
    end else begin
      rd_idx_s = IW'(ptr_r - DW'(1));
    end
    rdata = mem_r[rd_idx_s];
    depth = ptr_r;
  end

  // Fill pointer; reset empties the stack.
  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr_r <= DW'(0);
    end else if (do_push_s) begin
      ptr_r <= ptr_r + DW'(1);
    end else if (do_pop_s) begin
      ptr_r <= ptr_r - DW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Entry storage; contents need no reset since depth gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_idx_s] <= wdata;
    end
  end

endmodule

// File: rtl/prog_ctr_ras.sv
// Fetch-stage program counter: increment, jump, relative branch, call/return via RAS, stall, halt.
module prog_ctr_ras
  import pc_pkg::*;
#(
  parameter  int A  = 10,
  parameter  int D  = 8,
  parameter  int OW = 8,
  localparam int DW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          Stall,
  input  logic          Halt,
  input  pc_op_t        Op,
  input  logic          Cond,
  input  logic [A-1:0]  Target,
  input  logic [OW-1:0] Offset,
  output logic [A-1:0]  ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic          Fault,
  output pc_fault_t     FaultCode,
  output logic [DW-1:0] Depth
);

  pc_state_t     state_r, state_nxt_s;
  pc_fault_t     code_r, code_nxt_s;
  logic [A-1:0]  pc_r, pc_nxt_s, pc_inc_s, off_s, rdata_s;
  logic          active_s, push_s, pop_s, full_s, empty_s;
  logic [DW-1:0] depth_s;

  ras_stack #(.A(A), .D(D)) u_ras (
    .clk   (clk),
    .Reset (Reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pc_inc_s),
    .rdata (rdata_s),
    .depth (depth_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // State, PC and fault-code registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_BOOT;
      pc_r    <= A'(0);
      code_r  <= NONE;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      code_r  <= code_nxt_s;
    end
  end

  // Next state: Done and Fault are terminal until Reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (Halt) begin
          state_nxt_s = ST_DONE;
        end else if (Stall) begin
          state_nxt_s = ST_RUN;
        end else if ((Op == PC_CALL) && full_s) begin
          state_nxt_s = ST_FAULT;
        end else if ((Op == PC_RET) && empty_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE:  state_nxt_s = ST_DONE;
      ST_FAULT: state_nxt_s = ST_FAULT;
      default:  state_nxt_s = ST_BOOT;
    endcase
  end

  // Next-PC mux and stack control; a faulting call/return leaves the PC where it is.
  always_comb begin
    pc_inc_s   = pc_r + A'(1);
    off_s      = A'(sext_off(32'(Offset), OW));
    active_s   = (state_r == ST_RUN) && !Halt && !Stall;
    pc_nxt_s   = pc_r;
    code_nxt_s = code_r;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    if (active_s) begin
      case (Op)
        PC_JMP: pc_nxt_s = Target;
        PC_BR: begin
          if (Cond) begin
            pc_nxt_s = pc_r + off_s;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
        end
        PC_CALL: begin
          if (full_s) begin
            code_nxt_s = OVF;
          end else begin
            push_s   = 1'b1;
            pc_nxt_s = Target;
          end
        end
        PC_RET: begin
          if (empty_s) begin
            code_nxt_s = UNF;
          end else begin
            pop_s    = 1'b1;
            pc_nxt_s = rdata_s;
          end
        end
        default: pc_nxt_s = pc_inc_s;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Output decode, driven only from registers.
  always_comb begin
    ProgCtr   = pc_r;
    FaultCode = code_r;
    Depth     = depth_s;
    Running   = (state_r != ST_BOOT);
    Done      = (state_r == ST_DONE);
    Fault     = (state_r == ST_FAULT);
  end

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Directed bench for prog_ctr_ras: the driver queues hand-computed expectations, a monitor checks them after each edge.
module tb_prog_ctr_ras;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        Reset = 1'b1, Stall = 1'b0, Halt = 1'b0, Cond = 1'b0;
  pc_op_t      Op = PC_INC;
  logic [9:0]  Target = 10'd0;
  logic [7:0]  Offset = 8'd0;
  logic [9:0]  ProgCtr;
  logic        Running, Done, Fault;
  pc_fault_t   FaultCode;
  logic [3:0]  Depth;

  typedef struct packed {
    logic [9:0] pc;
    logic       run;
    logic       done;
    logic       flt;
    logic [1:0] code;
    logic [3:0] dep;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  prog_ctr_ras #(.A(10), .D(8), .OW(8)) dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Halt(Halt), .Op(Op), .Cond(Cond),
    .Target(Target), .Offset(Offset), .ProgCtr(ProgCtr), .Running(Running),
    .Done(Done), .Fault(Fault), .FaultCode(FaultCode), .Depth(Depth)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{pc: ProgCtr, run: Running, done: Done, flt: Fault, code: FaultCode, dep: Depth};
      total++;
      step_no++;
      if (a !== e) begin
        bad++;
        $display("FAIL step%0d: got pc=%0d run=%0b done=%0b flt=%0b code=%0d dep=%0d, want pc=%0d run=%0b done=%0b flt=%0b code=%0d dep=%0d",
                 step_no, a.pc, a.run, a.done, a.flt, a.code, a.dep,
                 e.pc, e.run, e.done, e.flt, e.code, e.dep);
      end
    end
  end

  task automatic s(input pc_op_t op, input logic [9:0] tgt, input logic [7:0] off,
                   input logic cnd, input logic stl, input logic hlt, input logic rst,
                   input logic [9:0] epc, input logic erun, input logic edone,
                   input logic eflt, input pc_fault_t ecode, input logic [3:0] edep);
    @(negedge clk);
    Op = op; Target = tgt; Offset = off; Cond = cnd; Stall = stl; Halt = hlt; Reset = rst;
    exp_q.push_back('{pc: epc, run: erun, done: edone, flt: eflt, code: ecode, dep: edep});
  endtask

  initial begin
    // 1: reset, bubble, increments
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_JMP, 10'd77, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    for (int i = 1; i <= 5; i++)
      s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(i), 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // 2: branches and wrap
    s(PC_BR,  10'd0, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0, 10'd2, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_JMP, 10'd5, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd5, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_BR,  10'd0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 10'd6, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_JMP, 10'd1023, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1023, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // 3: call / return
    s(PC_JMP, 10'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd3, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_CALL, 10'd100, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 1'b1, 1'b0, 1'b0, NONE, 4'd1);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd101, 1'b1, 1'b0, 1'b0, NONE, 4'd1);
    s(PC_RET, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd4, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // wrapped return address, negative branch from 0, undefined op
    s(PC_JMP, 10'd1023, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1023, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_CALL, 10'd10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd10, 1'b1, 1'b0, 1'b0, NONE, 4'd1);
    s(PC_RET, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_BR,  10'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1023, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(pc_op_t'(3'd7), 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // 6a: stall with call holds everything
    for (int i = 0; i < 3; i++)
      s(PC_CALL, 10'd20, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // 5: underflow, then frozen
    s(PC_RET, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b1, UNF, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b1, UNF, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // 4: nested calls to full, pop one, refill, overflow
    for (int k = 1; k <= 8; k++)
      s(PC_CALL, 10'(16 * k), 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(16 * k), 1'b1, 1'b0, 1'b0, NONE, 4'(k));
    s(PC_RET, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd113, 1'b1, 1'b0, 1'b0, NONE, 4'd7);
    s(PC_CALL, 10'd128, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd128, 1'b1, 1'b0, 1'b0, NONE, 4'd8);
    s(PC_CALL, 10'd200, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd128, 1'b1, 1'b0, 1'b1, OVF, 4'd8);
    s(PC_RET, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd128, 1'b1, 1'b0, 1'b1, OVF, 4'd8);
    s(PC_CALL, 10'd9, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    // 6b: halt beats a pending call
    s(PC_CALL, 10'd50, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 1'b1, 1'b0, 1'b0, NONE, 4'd1);
    for (int i = 0; i < 3; i++)
      s(PC_CALL, 10'd60, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd50, 1'b1, 1'b0, 1'b0, NONE, 4'd1);
    s(PC_CALL, 10'd60, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd50, 1'b1, 1'b1, 1'b0, NONE, 4'd1);
    s(PC_RET, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd50, 1'b1, 1'b1, 1'b0, NONE, 4'd1);
    // 6c: reset mid-stall
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, NONE, 4'd0);
    s(PC_INC, 10'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, NONE, 4'd0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
